// File: rtl/logic_sched_pkg.sv
// rtl/logic_sched_pkg.sv - shared widths, default sizes and the issue tag type
package logic_sched_pkg;
  localparam int CTRL_W     = 2;
  localparam int DATA_W     = 64;
  localparam int NREQ_DEF   = 4;
  localparam int LU_LAT_DEF = 1;
  localparam int DEPTH_DEF  = 4;
  // Wide enough for the largest supported requester count (8).
  localparam int TAG_IDW    = 3;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;
endpackage

// File: rtl/logic_sched_if.sv
// rtl/logic_sched_if.sv - requester, logic-unit and response signals of logic_sched
interface logic_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import logic_sched_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [CTRL_W*NREQ-1:0] req_ctrl;
  logic [DATA_W*NREQ-1:0] req_op1;
  logic [DATA_W*NREQ-1:0] req_op2;
  logic [CTRL_W-1:0]      lu_ctrl;
  logic [DATA_W-1:0]      lu_op1;
  logic [DATA_W-1:0]      lu_op2;
  logic [DATA_W-1:0]      lu_dst;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [DATA_W-1:0]      rsp_data;

  modport master (
    output req_valid, req_ctrl, req_op1, req_op2, lu_dst, rsp_ready,
    input  req_ready, lu_ctrl, lu_op1, lu_op2, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_ctrl, req_op1, req_op2, lu_dst, rsp_ready,
    output req_ready, lu_ctrl, lu_op1, lu_op2, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/logic_sched_fifo.sv
// rtl/logic_sched_fifo.sv - synchronous result FIFO with occupancy count
module logic_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 66,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/logic_sched.sv
// rtl/logic_sched.sv - round-robin sharing of one logic unit with in-order tagged results
// LOGIC_SCHED_FIXED_PRIO_EN selects lowest-index-wins arbitration instead of round robin.
module logic_sched
  import logic_sched_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int IDW    = $clog2(NREQ),
  parameter int LU_LAT = LU_LAT_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  logic_sched_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = IDW + DATA_W;

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    gnt_id;
  logic              gnt_found;
  logic [NREQ-1:0]   ready_vec;
  logic              issue;
  logic [CW-1:0]     credit_q;
  logic [CTRL_W-1:0] sel_ctrl;
  logic [DATA_W-1:0] sel_op1;
  logic [DATA_W-1:0] sel_op2;
  tag_t              tag_pipe [LU_LAT];
  tag_t              tag_out;
  logic              push;
  logic              pop;
  logic [FW-1:0]     head;
  logic [CW-1:0]     fifo_count;

  // Extra bit on the search index so the wrap compare works for any NREQ.
  always_comb begin : arb
    logic [IDW:0] j;
    j         = '0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = {1'b0, ptr} + (IDW + 1)'(k);
      if (j >= (IDW + 1)'(NREQ)) j = j - (IDW + 1)'(NREQ);
      if (!gnt_found && bus.req_valid[j[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = j[IDW-1:0];
      end
    end
  end

  assign issue = gnt_found && (credit_q != '0) && !rst;

  always_comb begin
    ready_vec = '0;
    sel_ctrl  = '0;
    sel_op1   = '0;
    sel_op2   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        ready_vec[i] = issue;
        sel_ctrl     = bus.req_ctrl[i*CTRL_W +: CTRL_W];
        sel_op1      = bus.req_op1[i*DATA_W +: DATA_W];
        sel_op2      = bus.req_op2[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.req_ready = ready_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      credit_q    <= CW'(DEPTH);
      bus.lu_ctrl <= '0;
      bus.lu_op1  <= '0;
      bus.lu_op2  <= '0;
    end else begin
      credit_q <= credit_q - CW'(issue) + CW'(pop);
      if (issue) begin
        bus.lu_ctrl <= sel_ctrl;
        bus.lu_op1  <= sel_op1;
        bus.lu_op2  <= sel_op2;
      end
`ifdef LOGIC_SCHED_FIXED_PRIO_EN
      ptr <= '0;
`else
      if (issue) ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LU_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0].valid <= issue;
      tag_pipe[0].id    <= TAG_IDW'(gnt_id);
      for (int k = 1; k < LU_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign tag_out = tag_pipe[LU_LAT-1];
  assign push    = tag_out.valid;
  assign pop     = (fifo_count != '0) && bus.rsp_ready;

  logic_sched_fifo #(
    .DEPTH (DEPTH),
    .W     (FW),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({IDW'(tag_out.id), bus.lu_dst}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.rsp_valid = (fifo_count != '0);
  assign bus.rsp_id    = bus.rsp_valid ? head[FW-1 -: IDW] : '0;
  assign bus.rsp_data  = bus.rsp_valid ? head[DATA_W-1:0] : '0;
endmodule

// File: tb/tb_logic_sched.sv
// tb/tb_logic_sched.sv - scoreboard bench for logic_sched with an XOR stub logic unit
module tb_logic_sched;
  import logic_sched_pkg::*;

  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int LU_LAT = 1;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  logic_sched #(
    .NREQ   (NREQ),
    .IDW    (IDW),
    .LU_LAT (LU_LAT),
    .DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [NREQ-1:0] v   = '0;
  logic            rdy = 1'b0;
  logic [63:0]     a [NREQ];
  logic [63:0]     b [NREQ];

  always_comb begin
    bus.req_valid = v;
    bus.rsp_ready = rdy;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ctrl[2*i +: 2]  = 2'(i);
      bus.req_op1[64*i +: 64] = a[i];
      bus.req_op2[64*i +: 64] = b[i];
    end
  end

  logic [63:0] lu_dly [LU_LAT];
  always @(posedge clk) begin
    lu_dly[0] <= bus.lu_op1 ^ bus.lu_op2;
    for (int s = 1; s < LU_LAT; s++) lu_dly[s] <= lu_dly[s-1];
  end
  assign bus.lu_dst = (LU_LAT == 1) ? (bus.lu_op1 ^ bus.lu_op2) : lu_dly[(LU_LAT > 1) ? LU_LAT - 2 : 0];

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    data;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  logic overflow_seen = 1'b0;
  int   ptr_m = 0;
  int   credit_m = DEPTH;
  logic [NREQ-1:0] s_v   = '0;
  logic [NREQ-1:0] s_rdy = '0;
  logic s_rst = 1'b1;
  logic s_pop = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  function automatic logic [NREQ-1:0] exp_ready(input logic [NREQ-1:0] vv, input int p,
                                                input int cr, input logic r);
    logic [NREQ-1:0] g;
    int j;
    g = '0;
    if (!r && cr > 0) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (p + k) % NREQ;
        if (vv[j] && g == '0) g[j] = 1'b1;
      end
    end
    return g;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    check("req_ready_model", bus.req_ready, exp_ready(v, ptr_m, credit_m, rst));
    for (int i = 0; i < NREQ; i++)
      if (v[i] && bus.req_ready[i]) sb.push_back('{id: IDW'(i), data: a[i] ^ b[i]});
    if (bus.rsp_valid && rdy) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL rsp_unexpected: actual id %0d data %0h required no response", bus.rsp_id, bus.rsp_data);
      end else begin
        e = sb.pop_front();
        check("rsp_id", bus.rsp_id, e.id);
        check("rsp_data", bus.rsp_data, e.data);
      end
    end
    if (dut.push && dut.fifo_count == 3'(DEPTH)) overflow_seen = 1'b1;
    s_v   = v;
    s_rdy = bus.req_ready;
    s_rst = rst;
    s_pop = bus.rsp_valid && rdy;
  end

  always @(posedge clk) begin
    if (s_rst) begin
      ptr_m    = 0;
      credit_m = DEPTH;
      sb.delete();
    end else begin
      credit_m = credit_m - int'(|(s_v & s_rdy)) + int'(s_pop);
      for (int i = 0; i < NREQ; i++) begin
        if (s_v[i] && s_rdy[i]) begin
`ifdef LOGIC_SCHED_FIXED_PRIO_EN
          ptr_m = 0;
`else
          ptr_m = (i + 1) % NREQ;
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int hs;
    logic [NREQ-1:0] g_exp;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_id", bus.rsp_id, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    check("reset_lu_ctrl", bus.lu_ctrl, 0);
    check("reset_lu_op1", bus.lu_op1, 0);
    check("reset_lu_op2", bus.lu_op2, 0);
    check("reset_credit", dut.credit_q, DEPTH);

    // Reset mid-stream with three ops in flight.
    tick();
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 64'h1111_0000 * (i + 1);
      b[i] = 64'h0000_0F0F;
    end
    v = 4'b0111;
    rdy = 1'b0;
    repeat (3) tick();
    v = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_req_ready", bus.req_ready, 0);
    check("midrst_credit", dut.credit_q, DEPTH);
    tick();
    rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("midrst_no_stale", bus.rsp_valid, 0);
      tick();
    end

    // Single op latency.
    a[2] = 64'hFF00;
    b[2] = 64'h0FF0;
    v = 4'b0100;
    @(negedge clk);
    check("single_ready", bus.req_ready, 4'b0100);
    tick();
    v = '0;
    for (int k = 0; k < LU_LAT; k++) begin
      @(negedge clk);
      check("single_early", bus.rsp_valid, 0);
      tick();
    end
    @(negedge clk);
    check("single_valid", bus.rsp_valid, 1);
    check("single_id", bus.rsp_id, 2);
    check("single_data", bus.rsp_data, 64'hF0F0);
    tick();
    @(negedge clk);
    check("single_popped", bus.rsp_valid, 0);

    // All requesters streaming.
    do_reset();
    v = 4'b1111;
    rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
`ifdef LOGIC_SCHED_FIXED_PRIO_EN
      g_exp = 4'b0001;
`else
      g_exp = 4'(1 << (k % 4));
`endif
      @(negedge clk);
      check("rr_grant", bus.req_ready, g_exp);
      tick();
      for (int i = 0; i < NREQ; i++) a[i] = a[i] + 64'h1_0000_0001;
    end
    v = '0;
    repeat (4) tick();

    // Backpressure: only DEPTH issues until the consumer drains.
    v = 4'b0010;
    rdy = 1'b0;
    hs = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.req_ready[1]) hs++;
      tick();
      a[1] = a[1] ^ (64'hA5 << (k * 4));
    end
    check("bp_handshakes", hs, DEPTH);
    @(negedge clk);
    check("bp_ready_low", bus.req_ready, 0);
    check("bp_rsp_valid", bus.rsp_valid, 1);
    check("bp_rsp_id", bus.rsp_id, 1);
    tick();
    rdy = 1'b1;
    hs = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.req_ready[1]) hs++;
      tick();
      b[1] = b[1] + 64'h0123_4567_89AB_CDEF;
    end
    check("bp_resume", hs > 0, 1);
    v = '0;
    repeat (6) tick();

    // FIFO at DEPTH-1, then pop and issue on one edge.
    v = 4'b0001;
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      a[0] = a[0] + 64'hFFFF_0000_0000_0001;
    end
    v = '0;
    repeat (LU_LAT + 1) tick();
    @(negedge clk);
    check("pi_fifo_count", dut.fifo_count, DEPTH - 1);
    tick();
    a[3] = 64'hDEAD_BEEF_0000_FFFF;
    b[3] = 64'h0000_FFFF_1234_5678;
    v = 4'b1000;
    rdy = 1'b1;
    @(negedge clk);
    check("pi_ready", bus.req_ready, 4'b1000);
    check("pi_rsp_valid", bus.rsp_valid, 1);
    tick();
    v = '0;
    @(negedge clk);
    check("pi_credit", dut.credit_q, 1);
    v = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      tick();
      rdy = (k % 3) != 0;
      for (int i = 0; i < NREQ; i++) b[i] = b[i] ^ (64'h1 << (k + 8 * i));
    end
    v = '0;
    rdy = 1'b1;
    repeat (8) tick();

    // Requesters 0 and 3 contending.
    do_reset();
    v = 4'b1001;
    for (int k = 0; k < 6; k++) begin
`ifdef LOGIC_SCHED_FIXED_PRIO_EN
      g_exp = 4'b0001;
`else
      g_exp = (k % 2 == 0) ? 4'b0001 : 4'b1000;
`endif
      @(negedge clk);
      check("pair_grant", bus.req_ready, g_exp);
      tick();
    end
    v = 4'b1000;
    @(negedge clk);
    check("pair_grant3", bus.req_ready, 4'b1000);
    tick();
    v = '0;
    repeat (6) tick();

    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("no_overflow", overflow_seen, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/logic_sched.md
Name: logic_sched

Overview:
- Shares the single 64-bit logic unit (ctrl[1:0], op1, op2 -> dst) among NREQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- Issues at most one operation per cycle into the fixed-latency unit, tags each issue with the requester ID, and returns results in issue order through a credit-protected result FIFO.
- Sits between the decode/issue stages and the logic unit.

Parameters:
- NREQ, 4: number of requesters (2..8).
- IDW, 2: requester ID width, equal to clog2(NREQ).
- LU_LAT, 1: logic unit latency in cycles, issue to dst valid (1..4).
- DEPTH, 4: result FIFO depth; must be >= LU_LAT+1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept.
- req_ctrl  in  2*NREQ  flattened ctrl; requester i uses bits [2i+1:2i].
- req_op1  in  64*NREQ  flattened op1; slice i.
- req_op2  in  64*NREQ  flattened op2; slice i.
- lu_ctrl  out  2  to logic unit ctrl.
- lu_op1  out  64  to logic unit op1.
- lu_op2  out  64  to logic unit op2.
- lu_dst  in  64  from logic unit dst; valid LU_LAT cycles after issue.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  IDW  requester that owns the result.
- rsp_data  out  64  result.

Behaviour:
- Reset (rst=1 at a clk edge) clears the following:
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - lu_ctrl/lu_op1/lu_op2=0.
  - Round-robin pointer=0 and credit count=DEPTH.
  - Tag pipeline all invalid and FIFO empty.
- Reset mid-operation discards all in-flight ops and queued results; no stale rsp_valid after reset.
- Credits:
  - credit = DEPTH - (in-flight ops + FIFO occupancy).
  - Issue is allowed only when credit>0, so the FIFO can never overflow even if rsp_ready is held low.
- Arbitration (combinational grant, registered issue):
  - Search from pointer p upward, with wrap, for the first i with req_valid[i]=1.
  - If credit>0, set req_ready[i]=1 for that i only, in the same cycle. All other req_ready bits are 0.
  - req_ready never depends on rsp_ready combinationally.
- Issue:
  - On handshake (req_valid[i] & req_ready[i]) register lu_ctrl/op1/op2 from slice i.
  - Push tag {valid=1, id=i} into an LU_LAT-deep shift pipeline.
  - Set p = (i+1) mod NREQ.
  - With no handshake, lu_* hold their last values and an invalid tag is shifted in.
- Capture: when the tag emerging from the pipeline is valid, push {id, lu_dst} into the FIFO.
- Latency: handshake at edge N -> lu_* valid after N -> FIFO push at edge N+LU_LAT -> rsp_valid high after that edge when the FIFO was empty. Minimum request-to-response is LU_LAT+1 cycles.
- Output:
  - rsp_valid = FIFO not empty; rsp_id/rsp_data show the FIFO head.
  - Pop on rsp_valid & rsp_ready.
- Simultaneous issue+pop on the same edge: credit unchanged.
- Simultaneous push+pop: occupancy unchanged. Push into a full FIFO is impossible by the credit rule; the bench asserts this.
- Full throughput: with rsp_ready=1 and at least one requester valid, one issue per cycle is sustained indefinitely.
- A requester may drop req_valid without a handshake; the arbiter takes no action on it.

Optional Feature:
- LOGIC_SCHED_FIXED_PRIO_EN:
  - When defined, arbitration is fixed priority: the lowest index wins and the pointer is unused and held at 0.
  - When undefined, the round-robin scheme above applies.
- Ports are the same in both builds.

Decomposition:
- Shared package/header logic_sched_pkg holds:
  - Logic-unit ctrl width (2) and data width (64).
  - The tag struct {valid, id}.
  - Default NREQ/LU_LAT/DEPTH constants.
- One sub-module: logic_sched_fifo, a synchronous FIFO (DEPTH x (IDW+64)) with push/pop/count. The arbiter, credit and tag pipeline stay in logic_sched.

Test Plan:
Bench uses a stub logic unit with registered dst = op1 ^ op2 after LU_LAT cycles for every ctrl.
1. Reset mid-stream: 3 ops in flight, rst=1 for 1 cycle -> next cycle rsp_valid=0, req_ready=0, credit=DEPTH, and no response for those ops ever appears.
2. Single op: req 2 sends op1=0xFF00, op2=0x0FF0, rsp_ready=1 -> exactly LU_LAT+1 cycles later rsp_valid=1, rsp_id=2, rsp_data=0xF0F0.
3. Round robin: all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1...; each rsp_id matches issue order; one issue per cycle.
4. Backpressure: rsp_ready=0, requester 1 streaming -> exactly DEPTH=4 handshakes, then req_ready=0. Raise rsp_ready -> 4 results in order and issue resumes.
5. Pop+issue same edge with FIFO at DEPTH-1 -> no overflow and no lost result; the scoreboard matches all 64-bit values.
6. With LOGIC_SCHED_FIXED_PRIO_EN defined, requesters 0 and 3 valid continuously -> requester 3 is never granted while 0 stays valid. When 0 deasserts, 3 is granted the next cycle.
